// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared default sizing and threshold constants for sync_fifo_param.
package sync_fifo_pkg;
  localparam int FIFO_WIDTH_DEF = 8;
  localparam int FIFO_PTR_DEF = 4;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int AFULL_DEF = 12;
  localparam int AEMPTY_DEF = 4;
  localparam int PTR_W_DEF = FIFO_PTR_DEF + 1;
  // Pointers and count carry one extra wrap bit over the address width.
  function automatic int ptr_w(input int ptr);
    return ptr + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_param_mem.sv
// fifo_mem: unreset 1W/1R storage; registered read port, or async read when SYNC_FIFO_FWFT_EN is defined.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH_DEF,
  parameter int ADDR_W = FIFO_PTR_DEF
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] ram [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) ram[waddr] <= wdata;
`ifdef SYNC_FIFO_FWFT_EN
  logic unused;
  assign unused = rstb ^ re;
  assign rdata = ram[raddr];
`else
  // Nonblocking write keeps a same-edge read at the old word.
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) rdata <= '0;
    else if (re) rdata <= ram[raddr];
`endif
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered flags/count and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is 1-cycle registered read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH    = FIFO_WIDTH_DEF,
  parameter int FIFO_PTR      = FIFO_PTR_DEF,
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int AFULL_THRESH  = AFULL_DEF,
  parameter int AEMPTY_THRESH = AEMPTY_DEF
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rstb,
  input  logic                  fifo_wren,
  input  logic [FIFO_WIDTH-1:0] fifo_wrdata,
  input  logic                  fifo_rden,
  output logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_rdvalid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_afull,
  output logic                  fifo_aempty,
  output logic [FIFO_PTR:0]     fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);
  localparam int PW = ptr_w(FIFO_PTR);
  localparam logic [PW-1:0] AF = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE = PW'(AEMPTY_THRESH);
  if (FIFO_DEPTH != 2**FIFO_PTR) begin : g_bad_depth
    $error("FIFO_DEPTH must equal 2**FIFO_PTR");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH-1 || AEMPTY_THRESH < 1 || AEMPTY_THRESH > FIFO_DEPTH-1) begin : g_bad_thresh
    $error("thresholds must lie in 1..FIFO_DEPTH-1");
  end
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, cnt_nxt;
  logic wr_ok, rd_ok;
  logic [FIFO_WIDTH-1:0] mem_rd;
  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  always_comb begin
    rd_ok = fifo_rden && !fifo_empty;
    wr_ok = fifo_wren && (!fifo_full || rd_ok);
    wr_nxt = wr_ptr + PW'(wr_ok);
    rd_nxt = rd_ptr + PW'(rd_ok);
    cnt_nxt = wr_nxt - rd_nxt;
  end
  always_ff @(posedge fifo_clk or negedge fifo_rstb)
    if (!fifo_rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      fifo_full <= 1'b0;
      fifo_empty <= 1'b1;
      fifo_afull <= 1'b0;
      fifo_aempty <= 1'b1;
      fifo_overflow <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      fifo_count <= cnt_nxt;
      fifo_full <= (wr_nxt[PW-1] != rd_nxt[PW-1]) && (wr_nxt[PW-2:0] == rd_nxt[PW-2:0]);
      fifo_empty <= wr_nxt == rd_nxt;
      fifo_afull <= cnt_nxt >= AF;
      fifo_aempty <= cnt_nxt <= AE;
      fifo_overflow <= fifo_wren && !wr_ok;
      fifo_underflow <= fifo_rden && !rd_ok;
    end
  fifo_mem #(.WIDTH(FIFO_WIDTH), .ADDR_W(FIFO_PTR)) u_mem (
    .clk(fifo_clk),
    .rstb(fifo_rstb),
    .we(wr_ok),
    .waddr(wr_ptr[FIFO_PTR-1:0]),
    .wdata(fifo_wrdata),
    .re(rd_ok),
    .raddr(rd_ptr[FIFO_PTR-1:0]),
    .rdata(mem_rd)
  );
`ifdef SYNC_FIFO_FWFT_EN
  assign fifo_rddata = fifo_empty ? '0 : mem_rd;
  assign fifo_rdvalid = !fifo_empty;
`else
  assign fifo_rddata = mem_rd;
  always_ff @(posedge fifo_clk or negedge fifo_rstb)
    if (!fifo_rstb) fifo_rdvalid <= 1'b0;
    else fifo_rdvalid <= rd_ok;
`endif
endmodule
